// File: rtl/ddr_burst_wr_packer_pkg.sv
// ddr_wr_pkg: constants and types shared by the DDR burst write packer.
//   state_e          : packer FSM encoding (IDLE, CMD, DATA)
//   *_DEF            : default widths and burst length used by the top level
//   WORDS_PER_BEAT   : FIFO words packed into one DDR beat
//   BYTES_PER_BURST  : cmd_addr increment between consecutive bursts
package ddr_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int unsigned IN_W_DEF        = 16;
  localparam int unsigned OUT_W_DEF       = 128;
  localparam int unsigned BURST_LEN_DEF   = 16;
  localparam int unsigned WORDS_PER_BEAT  = OUT_W_DEF / IN_W_DEF;
  localparam int unsigned BYTES_PER_BURST = BURST_LEN_DEF * OUT_W_DEF / 8;

endpackage

// File: rtl/ddr_burst_wr_packer_word_packer.sv
// word_packer_16to128: collects OUT_W/IN_W FIFO words into one output beat.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   pop_i          : a word is taken from word_i this cycle
//   word_i         : FIFO head word
//   beat_ready_i   : downstream accepts beat_o when beat_valid_o is high
//   beat_o         : packed beat, first popped word in the LSBs
//   beat_valid_o   : beat_o holds a complete beat
// Words 0..WPB-2 wait in a shift/pack register; the final word is merged
// straight into the output register so the beat is valid one cycle after the
// last pop. The caller only pops while the output register is empty or being
// drained, so a beat is never overwritten before it is accepted.
module word_packer_16to128 import ddr_wr_pkg::*; #(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pop_i,
  input  logic [IN_W-1:0]  word_i,
  input  logic             beat_ready_i,
  output logic [OUT_W-1:0] beat_o,
  output logic             beat_valid_o
);

  localparam int unsigned WPB = OUT_W / IN_W;
  localparam int unsigned CW  = $clog2(WPB);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [OUT_W-IN_W-1:0] sh_q, sh_d;
  logic [OUT_W-1:0]      beat_q, beat_d;
  logic                  valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    if (valid_q && beat_ready_i) begin
      valid_d = 1'b0;
    end
    if (pop_i) begin
      if (cnt_q == CW'(WPB - 1)) begin
        beat_d  = {word_i, sh_q};
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        sh_d[cnt_q*IN_W +: IN_W] = word_i;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  assign beat_o       = beat_q;
  assign beat_valid_o = valid_q;

endmodule

// File: rtl/ddr_burst_wr_packer.sv
// ddr_burst_wr_packer: pops 16-bit words from a show-ahead FIFO, packs them
// into 128-bit beats and issues fixed-length burst writes over one frame
// buffer, wrapping the address at frame end.
//   rd_clk, rd_rst_n          : clock, asynchronous active-low reset
//   enable                    : level, gates the start of new bursts only
//   frame_start               : pulse, restart addressing at FRAME_BASE
//   fifo_rd_en/vld/data       : FIFO pop, head valid, head word
//   cmd_valid/ready/addr/len  : burst write command channel
//   wdata_valid/ready/wdata/wdata_last : write data channel
//   busy                      : FSM not in IDLE
//   frame_done                : pulse after the last beat of a frame
//   dbg_state                 : current FSM state
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Once raised, valid and its payload hold until that transfer; ready may
// change freely and never gates valid.
module ddr_burst_wr_packer import ddr_wr_pkg::*; #(
  parameter int unsigned       IN_W        = IN_W_DEF,
  parameter int unsigned       OUT_W       = OUT_W_DEF,
  parameter int unsigned       BURST_LEN   = BURST_LEN_DEF,
  parameter int unsigned       ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] FRAME_BASE  = '0,
  parameter int unsigned       FRAME_BEATS = 115200
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic              enable,
  input  logic              frame_start,
  output logic              fifo_rd_en,
  input  logic              fifo_rd_vld,
  input  logic [IN_W-1:0]   fifo_rd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  output logic              wdata_valid,
  input  logic              wdata_ready,
  output logic [OUT_W-1:0]  wdata,
  output logic              wdata_last,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        dbg_state
);

  localparam int unsigned WPB             = OUT_W / IN_W;
  localparam int unsigned WORDS_PER_BURST = BURST_LEN * WPB;
  localparam int unsigned BPB             = BURST_LEN * OUT_W / 8;
  localparam int unsigned WCW             = $clog2(WORDS_PER_BURST + 1);
  localparam int unsigned BCW             = $clog2(BURST_LEN);
  localparam int unsigned FCW             = $clog2(FRAME_BEATS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
  logic              pending_q, pending_d;
  logic              frame_done_q, frame_done_d;

  logic beat_accept;
  logic last_accept;
  logic wrap;

  word_packer_16to128 #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_packer (
    .clk_i        (rd_clk),
    .rst_ni       (rd_rst_n),
    .pop_i        (fifo_rd_en),
    .word_i       (fifo_rd_data),
    .beat_ready_i (wdata_ready),
    .beat_o       (wdata),
    .beat_valid_o (wdata_valid)
  );

  assign beat_accept = wdata_valid && wdata_ready;
  assign last_accept = beat_accept && (beat_cnt_q == BCW'(BURST_LEN - 1));
  // FRAME_BEATS is a whole number of bursts, so the wrap always lands on a
  // last beat and the address reload happens on the DATA->IDLE edge.
  assign wrap        = beat_accept && (frame_cnt_q == FCW'(FRAME_BEATS - 1));

  // Pop only while the output register is free or draining this cycle.
  assign fifo_rd_en = (state_q == DATA) && fifo_rd_vld &&
                      (word_cnt_q != WCW'(WORDS_PER_BURST)) &&
                      (!wdata_valid || wdata_ready);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_cnt_d   = word_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    pending_d    = pending_q;
    frame_done_d = wrap;

    if (fifo_rd_en) begin
      word_cnt_d = word_cnt_q + WCW'(1);
    end
    if (beat_accept) begin
      beat_cnt_d  = last_accept ? '0 : beat_cnt_q + BCW'(1);
      frame_cnt_d = wrap ? '0 : frame_cnt_q + FCW'(1);
    end

    case (state_q)
      IDLE: begin
        if (frame_start || pending_q) begin
          addr_d      = FRAME_BASE;
          frame_cnt_d = '0;
          pending_d   = 1'b0;
        end
        if (enable && fifo_rd_vld) begin
          state_d = CMD;
        end
      end
      CMD: begin
        // An issued command is never altered: defer frame_start to IDLE.
        if (frame_start) begin
          pending_d = 1'b1;
        end
        if (cmd_ready) begin
          state_d    = DATA;
          word_cnt_d = '0;
        end
      end
      DATA: begin
        if (frame_start) begin
          pending_d = 1'b1;
        end
        if (last_accept) begin
          state_d = IDLE;
          if (wrap || pending_q || frame_start) begin
            addr_d      = FRAME_BASE;
            frame_cnt_d = '0;
            pending_d   = 1'b0;
          end else begin
            addr_d = addr_q + ADDR_W'(BPB);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q      <= IDLE;
      addr_q       <= FRAME_BASE;
      word_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_cnt_q   <= word_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cmd_valid  = (state_q == CMD);
  assign cmd_addr   = addr_q;
  assign cmd_len    = 8'(BURST_LEN - 1);
  assign wdata_last = wdata_valid && (beat_cnt_q == BCW'(BURST_LEN - 1));
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ddr_burst_wr_packer.sv
// Self-checking bench for ddr_burst_wr_packer with a 32-beat frame.
// A FIFO model feeds words; each group of 8 pushed words becomes an expected
// beat in exp_q, and expected command addresses go to exp_addr_q.
module tb_ddr_burst_wr_packer;

  localparam int IN_W        = 16;
  localparam int OUT_W       = 128;
  localparam int ADDR_W      = 28;
  localparam int BURST_LEN   = 16;
  localparam int FRAME_BEATS = 32;

  logic              rd_clk = 1'b0;
  logic              rd_rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              frame_start = 1'b0;
  logic              fifo_rd_vld = 1'b0;
  logic [IN_W-1:0]   fifo_rd_data = '0;
  logic              cmd_ready = 1'b0;
  logic              wdata_ready = 1'b0;
  logic              fifo_rd_en;
  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              wdata_valid;
  logic [OUT_W-1:0]  wdata;
  logic              wdata_last;
  logic              busy;
  logic              frame_done;
  logic [1:0]        dbg_state;

  always #5 rd_clk = ~rd_clk;

  ddr_burst_wr_packer #(
    .FRAME_BEATS (FRAME_BEATS)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .enable       (enable),
    .frame_start  (frame_start),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wdata_valid  (wdata_valid),
    .wdata_ready  (wdata_ready),
    .wdata        (wdata),
    .wdata_last   (wdata_last),
    .busy         (busy),
    .frame_done   (frame_done),
    .dbg_state    (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [IN_W-1:0]   fifo_q[$];
  logic [OUT_W-1:0]  exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [OUT_W-1:0]  pend_beat = '0;
  int                pend_words = 0;

  int beats_acc = 0;
  int beat_in_burst = 0;
  int last_cnt = 0;
  int frame_done_cnt = 0;
  int pop_cnt = 0;
  int cmd_cnt = 0;
  logic [OUT_W-1:0]  first_beat = '0;
  bit vld_rand = 1'b0;
  bit rdy_toggle = 1'b0;
  bit w_stall = 1'b0;
  bit c_stall = 1'b0;
  logic [OUT_W-1:0]  w_hold = '0;
  logic [ADDR_W-1:0] c_hold = '0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_fifo();
    if (fifo_q.size() > 0 && (!vld_rand || $urandom_range(0, 2) != 0)) begin
      fifo_rd_vld  = 1'b1;
      fifo_rd_data = fifo_q[0];
    end else begin
      fifo_rd_vld  = 1'b0;
      fifo_rd_data = IN_W'($urandom);
    end
  endtask

  task automatic push_words(int n, bit seq, int base);
    for (int i = 0; i < n; i++) begin
      logic [IN_W-1:0] w;
      w = seq ? IN_W'(base + i) : IN_W'($urandom);
      fifo_q.push_back(w);
      pend_beat[pend_words*IN_W +: IN_W] = w;
      pend_words++;
      if (pend_words == OUT_W / IN_W) begin
        exp_q.push_back(pend_beat);
        pend_words = 0;
      end
    end
    drive_fifo();
  endtask

  // One clock: check outputs at the falling edge, then update inputs just
  // after the rising edge that performed the handshakes seen here.
  task automatic cycle();
    bit popped;
    logic [OUT_W-1:0]  e;
    logic [ADDR_W-1:0] ea;
    @(negedge rd_clk);
    n_vec++;
    if ((fifo_rd_en && !fifo_rd_vld) || (wdata_last && !wdata_valid)) begin
      n_err++;
      $display("FAIL protocol: fifo_rd_en=%b fifo_rd_vld=%b wdata_last=%b wdata_valid=%b, required no pop without vld and no last without valid",
               fifo_rd_en, fifo_rd_vld, wdata_last, wdata_valid);
    end
    if (w_stall) begin
      n_vec++;
      if (wdata_valid !== 1'b1 || wdata !== w_hold) begin
        n_err++;
        $display("FAIL wdata_hold: valid=%b data=%h, required valid=1 data=%h", wdata_valid, wdata, w_hold);
      end
    end
    if (c_stall) begin
      n_vec++;
      if (cmd_valid !== 1'b1 || cmd_addr !== c_hold) begin
        n_err++;
        $display("FAIL cmd_hold: valid=%b addr=%h, required valid=1 addr=%h", cmd_valid, cmd_addr, c_hold);
      end
    end
    w_stall = wdata_valid && !wdata_ready;
    w_hold  = wdata;
    c_stall = cmd_valid && !cmd_ready;
    c_hold  = cmd_addr;
    if (wdata_valid && wdata_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_extra: got beat %h, required none", wdata);
      end else begin
        e = exp_q.pop_front();
        if (wdata !== e) begin
          n_err++;
          $display("FAIL beat_data: got %h, required %h", wdata, e);
        end
      end
      n_vec++;
      if (wdata_last !== (beat_in_burst == BURST_LEN - 1)) begin
        n_err++;
        $display("FAIL beat_last: beat %0d last=%b, required %b", beat_in_burst, wdata_last,
                 (beat_in_burst == BURST_LEN - 1));
      end
      if (wdata_last) last_cnt++;
      if (beat_in_burst == 0) first_beat = wdata;
      beat_in_burst = (beat_in_burst == BURST_LEN - 1) ? 0 : beat_in_burst + 1;
      beats_acc++;
    end
    if (cmd_valid && cmd_ready) begin
      n_vec++;
      cmd_cnt++;
      if (exp_addr_q.size() == 0) begin
        n_err++;
        $display("FAIL cmd_extra: got cmd addr %h, required none", cmd_addr);
      end else begin
        ea = exp_addr_q.pop_front();
        if (cmd_addr !== ea || cmd_len !== 8'd15) begin
          n_err++;
          $display("FAIL cmd_addr: got addr %h len %0d, required addr %h len 15", cmd_addr, cmd_len, ea);
        end
      end
    end
    if (frame_done) frame_done_cnt++;
    popped = fifo_rd_en && fifo_rd_vld;
    @(posedge rd_clk);
    #1;
    if (popped) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    if (rdy_toggle) wdata_ready = ~wdata_ready;
    drive_fifo();
  endtask

  task automatic run_beats(string name, int n, int budget);
    int target;
    int k;
    target = beats_acc + n;
    k = 0;
    while (beats_acc < target && k < budget) begin
      cycle();
      k++;
    end
    n_vec++;
    if (beats_acc < target) begin
      n_err++;
      $display("FAIL %s_timeout: %0d beats accepted, required %0d", name, beats_acc, target);
    end
  endtask

  task automatic check_int(string name, int got, int req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_vec(string name, logic [OUT_W-1:0] got, logic [OUT_W-1:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rd_rst_n = 1'b0;
    repeat (3) @(posedge rd_clk);
    #1;
    check_vec("reset_ctrl", OUT_W'({fifo_rd_en, cmd_valid, wdata_valid, wdata_last, busy, frame_done}), '0);
    check_vec("reset_wdata", wdata, '0);
    check_vec("reset_addr", OUT_W'(cmd_addr), '0);
    check_int("reset_len", int'(cmd_len), 15);
    check_int("reset_state", int'(dbg_state), 0);
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic test_idle_to_cmd();
    push_words(128, 1'b1, 0);
    cmd_ready   = 1'b0;
    wdata_ready = 1'b1;
    enable      = 1'b1;
    @(negedge rd_clk);
    check_int("idle_cmd_valid", int'({cmd_valid, busy}), 0);
    @(posedge rd_clk);
    @(negedge rd_clk);
    check_int("cmd_valid_next", int'(cmd_valid), 1);
    check_vec("cmd_addr_first", OUT_W'(cmd_addr), '0);
    check_int("cmd_len_first", int'(cmd_len), 15);
    @(posedge rd_clk);
    #1;
  endtask

  task automatic test_streaming();
    exp_addr_q.push_back(28'h0);
    cmd_ready = 1'b1;
    last_cnt  = 0;
    run_beats("stream", 16, 400);
    repeat (3) cycle();
    check_vec("stream_beat0", first_beat, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    check_int("stream_last_cnt", last_cnt, 1);
    check_int("stream_idle", int'(busy), 0);
    check_vec("stream_next_addr", OUT_W'(cmd_addr), OUT_W'(28'h100));
    check_int("stream_no_frame_done", frame_done_cnt, 0);
    check_int("stream_words_left", fifo_q.size(), 0);
  endtask

  task automatic test_backpressure();
    int p0;
    p0 = pop_cnt;
    last_cnt = 0;
    vld_rand = 1'b1;
    rdy_toggle = 1'b1;
    exp_addr_q.push_back(28'h100);
    push_words(128, 1'b0, 0);
    run_beats("bp", 16, 2000);
    repeat (3) cycle();
    vld_rand = 1'b0;
    rdy_toggle = 1'b0;
    wdata_ready = 1'b1;
    check_int("bp_pops", pop_cnt - p0, 128);
    check_int("bp_exp_empty", exp_q.size(), 0);
    check_int("bp_last_cnt", last_cnt, 1);
  endtask

  task automatic test_frame_wrap();
    check_int("wrap_frame_done", frame_done_cnt, 1);
    check_vec("wrap_addr", OUT_W'(cmd_addr), '0);
  endtask

  task automatic test_frame_start_mid_data();
    int b0;
    b0 = beats_acc;
    last_cnt = 0;
    exp_addr_q.push_back(28'h0);
    push_words(128, 1'b0, 0);
    run_beats("fs_pre", 5, 200);
    check_int("fs_busy", int'(dbg_state), 2);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    run_beats("fs_post", 16 - (beats_acc - b0), 400);
    repeat (3) cycle();
    check_int("fs_beats", beats_acc - b0, 16);
    check_int("fs_last_cnt", last_cnt, 1);
    check_vec("fs_next_addr", OUT_W'(cmd_addr), '0);
    check_int("fs_no_frame_done", frame_done_cnt, 1);
  endtask

  task automatic test_cmd_stall();
    int p0;
    int c0;
    p0 = pop_cnt;
    c0 = cmd_cnt;
    cmd_ready = 1'b0;
    exp_addr_q.push_back(28'h0);
    push_words(128, 1'b1, 16'h1000);
    repeat (20) cycle();
    check_int("stall_cmd_valid", int'(cmd_valid), 1);
    check_vec("stall_cmd_addr", OUT_W'(cmd_addr), '0);
    check_int("stall_no_pop", pop_cnt - p0, 0);
    check_int("stall_no_accept", cmd_cnt - c0, 0);
    cmd_ready = 1'b1;
    run_beats("stall", 16, 400);
    repeat (3) cycle();
    check_vec("stall_next_addr", OUT_W'(cmd_addr), OUT_W'(28'h100));
  endtask

  task automatic test_frame_start_idle();
    enable = 1'b0;
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    cycle();
    check_vec("fs_idle_addr", OUT_W'(cmd_addr), '0);
    check_int("fs_idle_busy", int'(busy), 0);
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    exp_addr_q.push_back(28'h0);
    push_words(128, 1'b0, 0);
    run_beats("rst_pre", 4, 200);
    check_int("rst_pre_busy", int'(busy), 1);
    rd_rst_n = 1'b0;
    #1;
    check_vec("rst_mid_ctrl", OUT_W'({fifo_rd_en, cmd_valid, wdata_valid, wdata_last, busy, frame_done}), '0);
    check_vec("rst_mid_wdata", wdata, '0);
    check_vec("rst_mid_addr", OUT_W'(cmd_addr), '0);
    fifo_q.delete();
    exp_q.delete();
    pend_words = 0;
    beat_in_burst = 0;
    w_stall = 1'b0;
    c_stall = 1'b0;
    drive_fifo();
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    @(posedge rd_clk);
    #1;
    check_int("rst_release_state", int'(dbg_state), 0);
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = frame_done_cnt;
    last_cnt = 0;
    exp_addr_q.push_back(28'h0);
    exp_addr_q.push_back(28'h100);
    push_words(256, 1'b1, 16'h2000);
    run_beats("b2b", 32, 800);
    repeat (3) cycle();
    check_int("b2b_last_cnt", last_cnt, 2);
    check_int("b2b_frame_done", frame_done_cnt - f0, 1);
    check_vec("b2b_wrap_addr", OUT_W'(cmd_addr), '0);
    check_int("b2b_exp_empty", exp_q.size() + exp_addr_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_idle_to_cmd();
    test_streaming();
    test_backpressure();
    test_frame_wrap();
    test_frame_start_mid_data();
    test_cmd_stall();
    test_frame_start_idle();
    test_reset_mid_burst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
